// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: START -> DATA -> PARITY (optional) -> STOP.
// Define UART_TX_TWO_STOP_EN to append a second stop cycle (STOP2) to every frame.
module uart_tx_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       ser_done,
   output logic       busy,
   output logic       ser_en,
   output logic [1:0] mux_sel,
   output logic       frame_done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] MUX_START  = 2'b00;
   localparam logic [1:0] MUX_STOP   = 2'b01;
   localparam logic [1:0] MUX_DATA   = 2'b10;
   localparam logic [1:0] MUX_PARITY = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
      S_STOP2  = 3'd5,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] w_bit_cnt_next;
   logic             r_par_en_q;
   logic             w_par_en_next;

   logic             w_busy_next;
   logic             w_ser_en_next;
   logic [1:0]       w_mux_sel_next;
   logic             w_frame_done_next;

   // Serializer status is reserved; the sequence is purely cycle-counted.
   logic             w_unused_ser_done;
   assign w_unused_ser_done = ser_done;

   always_comb begin
      w_next         = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_par_en_next  = r_par_en_q;

      case (r_state)
         S_IDLE: begin
            if (Data_Valid) begin
               w_next        = S_START;
               w_par_en_next = PAR_EN;
            end
         end
         S_START: begin
            w_next         = S_DATA;
            w_bit_cnt_next = '0;
         end
         S_DATA: begin
            if (r_bit_cnt == LAST_BIT) begin
               w_bit_cnt_next = '0;
               w_next         = r_par_en_q ? S_PARITY : S_STOP;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
         end
         S_PARITY: w_next = S_STOP;
`ifdef UART_TX_TWO_STOP_EN
         S_STOP:   w_next = S_STOP2;
         S_STOP2:  w_next = S_IDLE;
`else
         S_STOP:   w_next = S_IDLE;
`endif
         default: begin
            w_next         = S_IDLE;
            w_bit_cnt_next = '0;
            w_par_en_next  = 1'b0;
         end
      endcase

      // Outputs are decoded from the next state so the registered copy lines up with it.
      w_busy_next       = 1'b1;
      w_ser_en_next     = 1'b0;
      w_mux_sel_next    = MUX_STOP;
      w_frame_done_next = 1'b0;

      case (w_next)
         S_IDLE:   w_busy_next    = 1'b0;
         S_START:  w_mux_sel_next = MUX_START;
         S_DATA: begin
            w_ser_en_next  = 1'b1;
            w_mux_sel_next = MUX_DATA;
         end
         S_PARITY: w_mux_sel_next = MUX_PARITY;
`ifdef UART_TX_TWO_STOP_EN
         S_STOP:   w_frame_done_next = 1'b0;
         S_STOP2:  w_frame_done_next = 1'b1;
`else
         S_STOP:   w_frame_done_next = 1'b1;
`endif
         default:  w_busy_next    = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_par_en_q <= 1'b0;
         busy       <= 1'b0;
         ser_en     <= 1'b0;
         mux_sel    <= MUX_STOP;
         frame_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_par_en_q <= w_par_en_next;
         busy       <= w_busy_next;
         ser_en     <= w_ser_en_next;
         mux_sel    <= w_mux_sel_next;
         frame_done <= w_frame_done_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle expected outputs are queued when a request is
// driven and popped on each falling edge.
module tb_uart_tx_ctrl;

   logic       CLK;
   logic       RST;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       ser_done;
   logic       busy;
   logic       ser_en;
   logic [1:0] mux_sel;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0] mux;
      logic       busy;
      logic       ser;
      logic       fd;
   } exp_t;

   exp_t q[$];

   uart_tx_ctrl #(.WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .ser_done   (ser_done),
      .busy       (busy),
      .ser_en     (ser_en),
      .mux_sel    (mux_sel),
      .frame_done (frame_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench did not terminate");
   end

   function automatic exp_t mk(input logic [1:0] m, input logic b, input logic s, input logic f);
      exp_t e;
      e.mux  = m;
      e.busy = b;
      e.ser  = s;
      e.fd   = f;
      return e;
   endfunction

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic push_frame(input bit par);
      q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 8; i++) q.push_back(mk(2'b10, 1'b1, 1'b1, 1'b0));
      if (par) q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0));
`ifdef UART_TX_TWO_STOP_EN
      q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0));
`endif
      q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1));
   endtask

   task automatic check(input string tag, input exp_t e);
      total++;
      assert (mux_sel === e.mux) else begin
         bad++;
         $error("FAIL %s mux_sel got=%b want=%b", tag, mux_sel, e.mux);
      end
      total++;
      assert (busy === e.busy) else begin
         bad++;
         $error("FAIL %s busy got=%b want=%b", tag, busy, e.busy);
      end
      total++;
      assert (ser_en === e.ser) else begin
         bad++;
         $error("FAIL %s ser_en got=%b want=%b", tag, ser_en, e.ser);
      end
      total++;
      assert (frame_done === e.fd) else begin
         bad++;
         $error("FAIL %s frame_done got=%b want=%b", tag, frame_done, e.fd);
      end
   endtask

   task automatic step(input string tag);
      @(posedge CLK);
      @(negedge CLK);
      total++;
      assert (q.size() > 0) else begin
         bad++;
         $error("FAIL %s scoreboard empty got=0 want>0", tag);
      end
      if (q.size() > 0) check(tag, q.pop_front());
   endtask

   task automatic run_all(input string tag);
      while (q.size() > 0) step(tag);
   endtask

   initial begin
      RST        = 1'b1;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      ser_done   = 1'b0;

      // asynchronous reset before any clock edge
      #2 RST = 1'b0;
      #2 check("reset", mk(2'b01, 1'b0, 1'b0, 1'b0));
      @(negedge CLK);
      RST = 1'b1;
      push_idle(2);
      run_all("idle");

      // single request with parity
      Data_Valid = 1'b1;
      PAR_EN     = 1'b1;
      push_frame(1'b1);
      step("par1");
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      push_idle(2);
      run_all("par1");

      // single request without parity
      Data_Valid = 1'b1;
      PAR_EN     = 1'b0;
      push_frame(1'b0);
      step("par0");
      Data_Valid = 1'b0;
      push_idle(2);
      run_all("par0");

      // request held high: frames separated by exactly one idle cycle
      Data_Valid = 1'b1;
      PAR_EN     = 1'b1;
      push_frame(1'b1);
      push_idle(1);
      push_frame(1'b1);
      push_idle(1);
      push_frame(1'b1);
      run_all("b2b");
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      push_idle(2);
      run_all("b2b_end");

      // input changes during DATA must not alter the frame or start another
      Data_Valid = 1'b1;
      PAR_EN     = 1'b0;
      push_frame(1'b0);
      step("frozen");
      Data_Valid = 1'b0;
      step("frozen");
      step("frozen");
      PAR_EN     = 1'b1;
      Data_Valid = 1'b1;
      step("frozen");
      Data_Valid = 1'b0;
      step("frozen");
      PAR_EN     = 1'b0;
      step("frozen");
      PAR_EN     = 1'b1;
      push_idle(3);
      run_all("frozen");
      PAR_EN     = 1'b0;

      // reset pulse in the middle of DATA
      Data_Valid = 1'b1;
      push_frame(1'b1);
      PAR_EN     = 1'b1;
      step("midrst");
      Data_Valid = 1'b0;
      for (int i = 0; i < 5; i++) step("midrst");
      #2 RST = 1'b0;
      #1 check("midrst_async", mk(2'b01, 1'b0, 1'b0, 1'b0));
      q.delete();
      @(negedge CLK);
      RST = 1'b1;
      push_idle(2);
      run_all("post_rst_idle");
      Data_Valid = 1'b1;
      PAR_EN     = 1'b1;
      push_frame(1'b1);
      step("post_rst");
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      push_idle(2);
      run_all("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
